// File: rtl/axi_rd_burst_master.sv
// AXI4 read burst master for the VDMA read path: one INCR burst per request,
// returned beats streamed into the line FIFO, frame address pointer kept here.
module axi_rd_burst_master #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    LSIZE       = 9,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES = ADDR_WIDTH'(32'h0020_0000)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  fsync,
    input  logic                  burst_req,
    input  logic                  tail_req,
    input  logic [LSIZE-1:0]      req_len,
    output logic                  resp,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_wr,
    input  logic                  fifo_full,
    output logic                  rd_err,
    output logic [ADDR_WIDTH-1:0] cur_addr
);

    // state  | meaning
    // S_IDLE | waiting for burst_req/tail_req; fsync reloads the frame pointer
    // S_ADDR | AR channel valid, waiting for m_arready
    // S_DATA | accepting R beats into the line FIFO until rlast
    // S_FIN  | done pulse, frame pointer advance/wrap/reload
    // S_ZERO | zero-length request: resp already pulsed, done next cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_FIN,
        S_ZERO
    } state_t;

    localparam int                    BPB_LOG2  = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] FRAME_END = BASE_ADDR + FRAME_BYTES;

    state_t                state, state_nxt;
    logic [LSIZE-1:0]      len_q;
    logic [LSIZE-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic                  fsync_pend;
    logic                  req_go;
    logic                  ar_hs;
    logic                  beat_ok;
    logic                  last_beat;
    logic                  addr_reload;

    // A request coinciding with fsync is ignored and re-sampled next cycle.
    assign req_go      = (state == S_IDLE) && !fsync && (burst_req || tail_req);
    assign ar_hs       = (state == S_ADDR) && m_arready;
    assign beat_ok     = (state == S_DATA) && m_rvalid && !fifo_full;
    assign last_beat   = beat_ok && m_rlast;
    assign addr_reload = fsync_pend || fsync;
    assign nxt_addr    = cur_addr + (ADDR_WIDTH'(len_q) << BPB_LOG2);

    assign m_araddr   = addr_q;
    assign m_arlen    = (state == S_ADDR) ? 8'(len_q - LSIZE'(1)) : 8'd0;
    assign m_arsize   = 3'(BPB_LOG2);
    assign m_arburst  = 2'b01;
    assign m_arvalid  = (state == S_ADDR);
    assign m_rready   = (state == S_DATA) && !fifo_full;
    assign fifo_wr    = beat_ok;
    assign fifo_wdata = m_rdata;

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_go) begin
                    state_nxt = (req_len == '0) ? S_ZERO : S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_arready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (last_beat) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            S_ZERO:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            resp       <= 1'b0;
            done       <= 1'b0;
            rd_err     <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
            beat_cnt   <= '0;
            fsync_pend <= 1'b0;
            cur_addr   <= BASE_ADDR;
        end else begin
            resp <= ar_hs || (req_go && (req_len == '0));
            done <= last_beat || (state == S_ZERO);

            if (req_go) begin
                len_q    <= req_len;
                addr_q   <= cur_addr;
                beat_cnt <= '0;
            end

            // rd_err is sticky until rst; fsync deliberately does not clear it.
            if (beat_ok) begin
                beat_cnt <= beat_cnt + LSIZE'(1);
                if (m_rresp != 2'b00) begin
                    rd_err <= 1'b1;
                end
                if (m_rlast && ((beat_cnt + LSIZE'(1)) != len_q)) begin
                    rd_err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    fsync_pend <= 1'b0;
                    if (fsync) begin
                        cur_addr <= BASE_ADDR;
                    end
                end
                S_FIN: begin
                    fsync_pend <= 1'b0;
                    if (addr_reload) begin
                        cur_addr <= BASE_ADDR;
                    end else if (nxt_addr >= FRAME_END) begin
                        cur_addr <= BASE_ADDR;
                    end else begin
                        cur_addr <= nxt_addr;
                    end
                end
                // A zero-length burst moves nothing, but a pending fsync is still honoured.
                S_ZERO: begin
                    fsync_pend <= 1'b0;
                    if (addr_reload) begin
                        cur_addr <= BASE_ADDR;
                    end
                end
                default: begin
                    if (fsync) begin
                        fsync_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master: a table of bursts driven through a
// small AXI read slave model, plus hand sequences for reset, fsync and zero length.
module tb_axi_rd_burst_master;

    localparam int          AW    = 32;
    localparam int          DW    = 64;
    localparam int          LS    = 9;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    // Small frame so the wrap point is reachable in a few bursts.
    localparam logic [31:0] FRAME = 32'h0000_1000;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          fsync = 1'b0;
    logic          burst_req = 1'b0;
    logic          tail_req = 1'b0;
    logic [LS-1:0] req_len = '0;
    logic          resp, done;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic          m_rlast = 1'b0;
    logic          m_rvalid = 1'b0;
    logic          m_rready;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_wr;
    logic          fifo_full = 1'b0;
    logic          rd_err;
    logic [AW-1:0] cur_addr;

    int n_chk = 0;
    int n_fail = 0;

    axi_rd_burst_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LSIZE      (LS),
        .BASE_ADDR  (BASE),
        .FRAME_BYTES(FRAME)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .fsync     (fsync),
        .burst_req (burst_req),
        .tail_req  (tail_req),
        .req_len   (req_len),
        .resp      (resp),
        .done      (done),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .fifo_wdata(fifo_wdata),
        .fifo_wr   (fifo_wr),
        .fifo_full (fifo_full),
        .rd_err    (rd_err),
        .cur_addr  (cur_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        tail;
        int          len;
        int          beats;
        int          stall;
        int          full_at;
        int          full_n;
        int          fsync_at;
        int          err_at;
        logic        pre_rst;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        logic [31:0] exp_cur;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    function automatic logic [63:0] pat(input int v, input int b);
        return {16'hA5C3, v[15:0], b[15:0], ~b[15:0]};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        fsync = 1'b0; burst_req = 1'b0; tail_req = 1'b0; req_len = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
        fifo_full = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        #1;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int cyc, stall, beat, wr_cnt, full_left, resp_extra, done_early;
        bit hs, full_done;
        @(negedge clock);
        if (v.tail) tail_req = 1'b1; else burst_req = 1'b1;
        req_len = LS'(v.len);
        cyc = 0; hs = 0; stall = v.stall;
        while (!hs && cyc < 200) begin
            @(negedge clock);
            cyc++;
            m_arready = (stall == 0);
            #1;
            if (cyc == 1) chk("arvalid_latency", m_arvalid, 1);
            if (m_arvalid) begin
                chk("araddr", m_araddr, v.exp_araddr);
                chk("arlen", m_arlen, v.exp_arlen);
                chk("arsize", m_arsize, 3);
                chk("arburst", m_arburst, 1);
                chk("resp_before_hs", resp, 0);
            end
            if (m_arvalid && m_arready) hs = 1;
            else if (m_arvalid && stall > 0) stall--;
        end
        if (!hs) begin
            timeout("ar_handshake");
            do_reset();
            return;
        end

        beat = 0; wr_cnt = 0; full_left = 0; full_done = 0; cyc = 0;
        resp_extra = 0; done_early = 0;
        while (beat < v.beats && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            m_arready = 1'b0;
            if (cyc == 2) begin
                burst_req = 1'b0;
                tail_req = 1'b0;
            end
            if (!full_done && beat == v.full_at) begin
                full_left = v.full_n;
                full_done = 1;
            end
            fifo_full = (full_left > 0);
            if (full_left > 0) full_left--;
            m_rvalid = 1'b1;
            m_rdata  = pat(vi, beat);
            m_rlast  = (beat == v.beats - 1);
            m_rresp  = (beat == v.err_at) ? 2'b10 : 2'b00;
            fsync    = (beat == v.fsync_at) && !fifo_full;
            #1;
            if (cyc == 1) begin
                chk("resp_pulse", resp, 1);
                chk("arvalid_dropped", m_arvalid, 0);
            end else if (resp) begin
                resp_extra++;
            end
            if (done) done_early++;
            chk("rready", m_rready, !fifo_full);
            chk("fifo_wr", fifo_wr, !fifo_full);
            if (fifo_wr) begin
                chk("wdata_order", fifo_wdata, pat(vi, wr_cnt));
                wr_cnt++;
            end
            if (m_rready) beat++;
        end
        if (beat < v.beats) begin
            timeout("data_phase");
            do_reset();
            return;
        end

        @(negedge clock);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; fsync = 1'b0; fifo_full = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("wr_count", wr_cnt, v.beats);
        chk("resp_once", resp_extra, 0);
        chk("done_early", done_early, 0);
        @(negedge clock);
        #1;
        chk("done_width", done, 0);
        chk("cur_addr", cur_addr, v.exp_cur);
        chk("rd_err", rd_err, v.exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           tail  len  bts st  fa  fn  fs  er  rst araddr        arlen  cur           err
        vecs[0] = '{1'b0, 200, 200, 0, -1, 0, -1, -1, 1'b0, 32'h1000_0000, 8'd199, 32'h1000_0640, 1'b0};
        vecs[1] = '{1'b1,  37,  37, 5, -1, 0, -1, -1, 1'b0, 32'h1000_0640, 8'd36,  32'h1000_0768, 1'b0};
        vecs[2] = '{1'b0, 200, 200, 0, 10, 5, -1, -1, 1'b0, 32'h1000_0768, 8'd199, 32'h1000_0DA8, 1'b0};
        vecs[3] = '{1'b0,  64,  64, 0, -1, 0, 50, -1, 1'b0, 32'h1000_0DA8, 8'd63,  32'h1000_0000, 1'b0};
        vecs[4] = '{1'b0, 200, 200, 0, -1, 0, -1, -1, 1'b0, 32'h1000_0000, 8'd199, 32'h1000_0640, 1'b0};
        vecs[5] = '{1'b1, 112, 112, 0, -1, 0, -1, -1, 1'b0, 32'h1000_0640, 8'd111, 32'h1000_09C0, 1'b0};
        vecs[6] = '{1'b0, 200, 200, 0, -1, 0, -1, -1, 1'b0, 32'h1000_09C0, 8'd199, 32'h1000_0000, 1'b0};
        vecs[7] = '{1'b0, 200, 199, 0, -1, 0, -1, -1, 1'b1, 32'h1000_0000, 8'd199, 32'h1000_0640, 1'b1};
        vecs[8] = '{1'b0,   8,   8, 0, -1, 0, -1,  3, 1'b1, 32'h1000_0000, 8'd7,   32'h1000_0040, 1'b1};

        do_reset();
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_resp", resp, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_cur_addr", cur_addr, BASE);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_rst) begin
                do_reset();
                chk("rerst_rd_err", rd_err, 0);
                chk("rerst_cur_addr", cur_addr, BASE);
            end
            run_vec(i, vecs[i]);
        end

        // fsync in IDLE reloads the pointer but leaves the error flag set
        @(negedge clock);
        fsync = 1'b1;
        @(negedge clock);
        fsync = 1'b0;
        #1;
        chk("err_sticky_fsync", rd_err, 1);
        chk("fsync_idle_cur_addr", cur_addr, BASE);

        // zero-length request: resp then done, no AR traffic
        @(negedge clock);
        burst_req = 1'b1;
        req_len = '0;
        @(negedge clock);
        #1;
        chk("zero_resp", resp, 1);
        chk("zero_done_early", done, 0);
        chk("zero_arvalid0", m_arvalid, 0);
        @(negedge clock);
        burst_req = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_resp_width", resp, 0);
        chk("zero_arvalid1", m_arvalid, 0);
        @(negedge clock);
        #1;
        chk("zero_done_width", done, 0);
        chk("zero_arvalid2", m_arvalid, 0);
        chk("zero_cur_addr", cur_addr, BASE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_master.md
Name: axi_rd_burst_master

Overview:
- Downstream of the read-FIFO status controller in the VDMA read path.
- Turns each burst_req/tail_req (with req_len) into one AXI4 INCR read burst.
- Writes the returned beats into the line FIFO.
- Reports resp (address accepted) and done (last beat stored) back to the controller.
- Keeps the frame address pointer: reset on fsync, advanced per burst, wrapped at frame end.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI/FIFO data width; power of two, 8..1024.
- LSIZE, 9, width of req_len; max 256 beats.
- BASE_ADDR, 32'h1000_0000, frame start address.
- FRAME_BYTES, 32'h0020_0000, frame size in bytes; wrap point.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- fsync  in  1  frame sync; address pointer returns to BASE_ADDR.
- burst_req  in  1  level request; full burst.
- tail_req  in  1  level request; tail burst.
- req_len  in  LSIZE  beats requested; sampled with the request.
- resp  out  1  1-cycle pulse; request accepted by AXI.
- done  out  1  1-cycle pulse; burst fully written to FIFO.
- m_araddr  out  ADDR_WIDTH  burst start address.
- m_arlen  out  8  beats-1.
- m_arsize  out  3  constant log2(DATA_WIDTH/8).
- m_arburst  out  2  constant 2'b01 (INCR).
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rdata  in  DATA_WIDTH  read data.
- m_rresp  in  2  read response.
- m_rlast  in  1  last beat.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- fifo_wr  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full backpressure.
- rd_err  out  1  sticky: rresp!=OKAY, or beat count != length at rlast.
- cur_addr  out  ADDR_WIDTH  current frame pointer (debug).

Behaviour:
- Reset: state IDLE; outputs 0, except cur_addr=BASE_ADDR. rd_err is cleared only by rst.
- Clearing the bus-error flag on fsync was considered and rejected; it stays sticky.
- Byte/beat: BPB = DATA_WIDTH/8. Address arithmetic is ADDR_WIDTH-bit unsigned.
- IDLE:
  - fsync=1 → cur_addr<=BASE_ADDR; any request that cycle is ignored and re-sampled next cycle.
  - Otherwise, if burst_req|tail_req: latch len=req_len and addr=cur_addr.
  - If len==0 → ZERO. Else → ADDR, with m_arvalid=1 the next cycle.
  - If both requests are high, the controller has erred; treat it as a single request using req_len.
- ADDR:
  - m_araddr=addr, m_arlen=len-1. m_arvalid is held until m_arready; AR fields stay stable while valid.
  - On handshake: m_arvalid<=0, resp<=1 for one cycle, → DATA.
- DATA:
  - m_rready = !fifo_full.
  - Beat accepted (m_rvalid&m_rready): fifo_wr=1, fifo_wdata=m_rdata in the same cycle (combinational, no extra latency); beat counter +1.
  - m_rresp!=2'b00 on any beat → rd_err<=1.
  - Accepted beat with m_rlast → FIN. If counter+1 != len at that point → rd_err<=1.
  - The burst ends only on rlast; no early termination.
- FIN (1 cycle):
  - done<=1 for one cycle.
  - If fsync was seen since leaving IDLE (fsync_pend) → cur_addr<=BASE_ADDR, clear pend.
  - Else nxt=cur_addr+len*BPB; cur_addr<= (nxt >= BASE_ADDR+FRAME_BYTES) ? BASE_ADDR : nxt.
  - → IDLE.
- ZERO: resp pulse; next cycle done pulse, no AXI traffic, cur_addr unchanged; → IDLE.
- Latency:
  - Request visible at cycle N → m_arvalid at N+1.
  - resp at the cycle after the AR handshake.
  - done at the cycle after the rlast beat.
  - Minimum back-to-back burst spacing is 1 IDLE cycle.
- fsync while not IDLE: set fsync_pend. The current burst completes normally.
- Request level held after resp (the controller drops it one cycle later) is never re-accepted: only IDLE samples requests, and IDLE is unreachable before done.
- Reset mid-burst: state returns to IDLE immediately, AXI outstanding data is abandoned. The system resets the interconnect together with this block.

Test Plan:
- Full burst: DATA_WIDTH=64, burst_req, req_len=200, arready immediate → araddr=0x1000_0000, arlen=199, arsize=3, arburst=1; resp one cycle after handshake; 200 fifo_wr; done one cycle after rlast; cur_addr=0x1000_0640.
- Tail burst + AR stall: tail_req, req_len=37, arready low 5 cycles → arvalid/fields held stable; arlen=36; cur_addr advances by 296 bytes.
- Backpressure: fifo_full high for beats 10-14 → m_rready=0 those cycles; exactly 200 writes; data order preserved.
- fsync mid-burst at beat 50 → burst completes, done pulses, cur_addr=BASE_ADDR; next request uses araddr=0x1000_0000.
- Wrap: cur_addr=BASE_ADDR+FRAME_BYTES-1600, req_len=200 → after done, cur_addr=BASE_ADDR.
- Errors and len=0:
  - Beat 3 rresp=2'b10 → rd_err=1 and stays sticky through fsync.
  - rlast at beat 199 with len=200 → rd_err=1, done still pulses.
  - req_len=0 → resp then done on consecutive cycles, no arvalid.
